// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states and the store-buffer entry payload.
package lsu_pkg;

    localparam int unsigned LSU_DATA_W = 64;
    localparam int unsigned LSU_ADDR_W = 64;
    localparam int unsigned LSU_RD_W   = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_ISSUE = 2'd1,
        DR_WRITE = 2'd2,
        DR_GAP   = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic [LSU_ADDR_W-1:0] index;
        logic [LSU_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/lsu_store_buffer.sv
// In-order store FIFO with a parallel search that returns the youngest entry matching a word index.
module lsu_store_buffer
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  sb_entry_t             i_push_entry,
    input  logic                  i_pop,
    input  logic [LSU_ADDR_W-1:0] i_search_index,
    output logic                  o_hit,
    output logic [LSU_DATA_W-1:0] o_hit_data,
    output sb_entry_t             o_head,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] w_count;
    logic [PTR_W-1:0] w_slot;
    sb_entry_t        r_entries [DEPTH];

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign o_head  = r_entries[r_rd_ptr[PTR_W-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push && !o_full) begin
                r_wr_ptr <= r_wr_ptr + CNT_W'(1);
            end
            if (i_pop && !o_empty) begin
                r_rd_ptr <= r_rd_ptr + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_entries[r_wr_ptr[PTR_W-1:0]] <= i_push_entry;
        end
    end

    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = '0;
        w_slot     = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_slot = r_rd_ptr[PTR_W-1:0] + PTR_W'(k);
            if ((CNT_W'(k) < w_count) && (r_entries[w_slot].index == i_search_index)) begin
                o_hit      = 1'b1;
                o_hit_data = r_entries[w_slot].data;
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: accepts LDUR/STUR requests, buffers stores with load forwarding,
// and drives Data_Memory with registered single-cycle strobes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_W     = LSU_DATA_W,
    parameter int unsigned SB_DEPTH   = 4,
    parameter int unsigned ADDR_SHIFT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [LSU_ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [LSU_RD_W-1:0]   req_rd,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [LSU_RD_W-1:0]   rsp_rd,
    output logic                  fault,
    output logic                  sb_empty,
    output logic [LSU_ADDR_W-1:0] mem_Address,
    output logic [DATA_W-1:0]     mem_WriteData,
    output logic                  mem_MemRead,
    output logic                  mem_MemWrite,
    input  logic [DATA_W-1:0]     mem_ReadData
);

    lsu_state_e            r_state,     w_state_nxt;
    logic [LSU_RD_W-1:0]   r_ld_rd,     w_ld_rd_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]     r_rsp_rdata, w_rsp_rdata_nxt;
    logic [LSU_RD_W-1:0]   r_rsp_rd,    w_rsp_rd_nxt;
    logic                  r_fault,     w_fault_nxt;
    logic [LSU_ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0]     r_mem_wdata, w_mem_wdata_nxt;
    logic                  r_mem_rd,    w_mem_rd_nxt;
    logic                  r_mem_wr,    w_mem_wr_nxt;

    logic                  w_accept;
    logic                  w_misalign;
    logic [LSU_ADDR_W-1:0] w_index;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_sb_full;
    logic                  w_sb_fifo_empty;
    logic                  w_hit;
    logic [LSU_DATA_W-1:0] w_hit_data;
    sb_entry_t             w_head;
    sb_entry_t             w_push_entry;

    assign w_index      = req_addr >> ADDR_SHIFT;
    assign w_misalign   = |req_addr[ADDR_SHIFT-1:0];
    assign req_ready    = (r_state == IDLE) & ~w_sb_full & ~rst;
    assign w_accept     = req_valid & req_ready;
    assign w_push_entry = '{index: w_index, data: LSU_DATA_W'(req_wdata)};

    lsu_store_buffer #(
        .DEPTH (SB_DEPTH)
    ) u_sb (
        .clk            (clk),
        .rst            (rst),
        .i_push         (w_push),
        .i_push_entry   (w_push_entry),
        .i_pop          (w_pop),
        .i_search_index (w_index),
        .o_hit          (w_hit),
        .o_hit_data     (w_hit_data),
        .o_head         (w_head),
        .o_full         (w_sb_full),
        .o_empty        (w_sb_fifo_empty)
    );

    // Next-state and registered-output logic; accepted requests take priority over draining.
    always_comb begin
        w_state_nxt     = r_state;
        w_ld_rd_nxt     = r_ld_rd;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_rd_nxt    = r_rsp_rd;
        w_fault_nxt     = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_rd_nxt    = 1'b0;
        w_mem_wr_nxt    = 1'b0;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_misalign) begin
                        w_fault_nxt = 1'b1;
                        if (!req_is_store) begin
                            w_rsp_valid_nxt = 1'b1;
                            w_rsp_rdata_nxt = '0;
                            w_rsp_rd_nxt    = req_rd;
                        end
                    end else if (req_is_store) begin
                        w_push = 1'b1;
                    end else if (w_hit) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_rdata_nxt = DATA_W'(w_hit_data);
                        w_rsp_rd_nxt    = req_rd;
                    end else begin
                        w_state_nxt    = LD_ISSUE;
                        w_mem_addr_nxt = w_index;
                        w_mem_rd_nxt   = 1'b1;
                        w_ld_rd_nxt    = req_rd;
                    end
                end else if (!w_sb_fifo_empty) begin
                    w_state_nxt     = DR_WRITE;
                    w_mem_addr_nxt  = w_head.index;
                    w_mem_wdata_nxt = DATA_W'(w_head.data);
                    w_mem_wr_nxt    = 1'b1;
                end
            end
            LD_ISSUE: begin
                w_state_nxt     = IDLE;
                w_rsp_valid_nxt = 1'b1;
                w_rsp_rdata_nxt = mem_ReadData;
                w_rsp_rd_nxt    = r_ld_rd;
            end
            DR_WRITE: begin
                w_state_nxt = DR_GAP;
                w_pop       = 1'b1;
            end
            DR_GAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ld_rd     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_rd    <= '0;
            r_fault     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ld_rd     <= w_ld_rd_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_rd    <= w_rsp_rd_nxt;
            r_fault     <= w_fault_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
        end
    end

    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_rd        = r_rsp_rd;
    assign fault         = r_fault;
    assign mem_Address   = r_mem_addr;
    assign mem_WriteData = r_mem_wdata;
    assign mem_MemRead   = r_mem_rd;
    assign mem_MemWrite  = r_mem_wr;
    assign sb_empty      = w_sb_fifo_empty & (r_state != DR_WRITE) & (r_state != DR_GAP);

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a program-order memory model with a pending-store queue.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        fault;
    logic        sb_empty;
    logic [63:0] mem_Address;
    logic [63:0] mem_WriteData;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [63:0] mem_ReadData;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_store  (req_is_store),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rd        (req_rd),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_rd        (rsp_rd),
        .fault         (fault),
        .sb_empty      (sb_empty),
        .mem_Address   (mem_Address),
        .mem_WriteData (mem_WriteData),
        .mem_MemRead   (mem_MemRead),
        .mem_MemWrite  (mem_MemWrite),
        .mem_ReadData  (mem_ReadData)
    );

    function automatic logic [63:0] init_val(input int i);
        return 64'h5A5A_0000_0000_0000 | 64'(i * 7 + 3);
    endfunction

    // Data_Memory stand-in: combinational read, write on the edge where MemWrite is high.
    logic [63:0] mem_arr [64];
    logic        tb_init;
    logic        tb_wr;
    logic [5:0]  tb_idx;
    logic [63:0] tb_val;

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= init_val(i);
        end else if (tb_wr) begin
            mem_arr[tb_idx] <= tb_val;
        end else if (mem_MemWrite) begin
            mem_arr[mem_Address[5:0]] <= mem_WriteData;
        end
    end
    assign mem_ReadData = mem_arr[mem_Address[5:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [63:0] idx; logic [63:0] data; } wr_t;
    typedef struct { int due; logic [63:0] data; logic [4:0] rd; } rsp_t;
    typedef struct { int due; logic [63:0] addr; } rdx_t;

    wr_t         pend_q  [$];
    rsp_t        rsp_q   [$];
    rdx_t        rd_q    [$];
    int          fault_q [$];
    logic [63:0] commit  [64];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    task automatic monitor();
        logic prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_MemRead | mem_MemWrite) begin
                check("strobe_excl", 64'(mem_MemRead & mem_MemWrite), 64'd0);
                check("strobe_gap", 64'(prev_strobe), 64'd0);
            end
            prev_strobe = mem_MemRead | mem_MemWrite;

            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                check("memread", 64'(mem_MemRead), 64'd1);
                check("read_addr", mem_Address, rd_q[0].addr);
                void'(rd_q.pop_front());
            end else if (mem_MemRead) begin
                check("read_spurious", 64'(mem_MemRead), 64'd0);
            end

            if (mem_MemWrite) begin
                if (pend_q.size() == 0) begin
                    check("write_spurious", 64'd1, 64'd0);
                end else begin
                    check("write_idx", mem_Address, pend_q[0].idx);
                    check("write_data", mem_WriteData, pend_q[0].data);
                    commit[pend_q[0].idx[5:0]] = pend_q[0].data;
                    void'(pend_q.pop_front());
                end
            end

            if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
                check("rsp_valid", 64'(rsp_valid), 64'd1);
                check("rsp_rdata", rsp_rdata, rsp_q[0].data);
                check("rsp_rd", 64'(rsp_rd), 64'(rsp_q[0].rd));
                void'(rsp_q.pop_front());
            end else if (rsp_valid) begin
                check("rsp_spurious", 64'(rsp_valid), 64'd0);
            end

            if (fault_q.size() > 0 && fault_q[0] == cyc) begin
                check("fault", 64'(fault), 64'd1);
                void'(fault_q.pop_front());
            end else if (fault) begin
                check("fault_spurious", 64'(fault), 64'd0);
            end
        end
    endtask

    // Present one request, wait for acceptance, and record what the model expects from it.
    task automatic send(input bit st, input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
        int          budget;
        logic [63:0] idx;
        bit          hit;
        logic [63:0] hv;
        rsp_t        r;
        rdx_t        x;
        wr_t         w;
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = st;
        req_addr     = addr;
        req_wdata    = wd;
        req_rd       = rd;
        budget       = 0;
        while (!req_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            check("ready_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        idx = addr >> 3;
        if (addr[2:0] != 3'd0) begin
            fault_q.push_back(cyc + 1);
            if (!st) begin
                r.due = cyc + 1; r.data = 64'd0; r.rd = rd;
                rsp_q.push_back(r);
            end
        end else if (st) begin
            w.idx = idx; w.data = wd;
            pend_q.push_back(w);
        end else begin
            hit = 1'b0;
            hv  = 64'd0;
            for (int i = pend_q.size() - 1; i >= 0; i--) begin
                if (pend_q[i].idx == idx) begin
                    hit = 1'b1;
                    hv  = pend_q[i].data;
                    break;
                end
            end
            r.rd = rd;
            if (hit) begin
                r.due = cyc + 1; r.data = hv;
            end else begin
                x.due = cyc + 1; x.addr = idx;
                rd_q.push_back(x);
                r.due = cyc + 2; r.data = commit[idx[5:0]];
            end
            rsp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int b = 0;
        @(negedge clk);
        while (!(sb_empty && pend_q.size() == 0) && b < 200) begin
            @(negedge clk);
            b++;
        end
        check({tag, "_sb_empty"}, 64'(sb_empty), 64'd1);
        check({tag, "_pending"}, 64'(pend_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic preload(input int idx, input logic [63:0] val);
        @(negedge clk);
        tb_wr = 1'b1; tb_idx = 6'(idx); tb_val = val;
        commit[idx] = val;
        @(negedge clk);
        tb_wr = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int b;
        rst = 1'b1; tb_init = 1'b1; tb_wr = 1'b0; tb_idx = '0; tb_val = '0;
        req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0; req_wdata = '0; req_rd = '0;
        for (int i = 0; i < 64; i++) commit[i] = init_val(i);
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        tb_init = 1'b0;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_sb_empty", 64'(sb_empty), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_strobes", 64'({mem_MemRead, mem_MemWrite}), 64'd0);
        check("rst_addr", mem_Address, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(req_ready), 64'd1);

        // Load miss through memory.
        preload(2, 64'hAB);
        send(1'b0, 64'h10, 64'd0, 5'd3);
        wait_drain("t1");

        // Store then forwarded load.
        send(1'b1, 64'h40, 64'hDEAD, 5'd0);
        send(1'b0, 64'h40, 64'd0, 5'd7);
        wait_drain("t2");

        // Youngest of two stores to one word is forwarded and ends in memory.
        send(1'b1, 64'h8, 64'd1, 5'd0);
        send(1'b1, 64'h8, 64'd2, 5'd0);
        send(1'b0, 64'h8, 64'd0, 5'd11);
        wait_drain("t3");
        check("t3_mem_w1", mem_arr[1], 64'd2);

        // Fill the buffer and watch it drain in order.
        for (int i = 0; i < 4; i++) send(1'b1, 64'(i * 8), 64'h1000 + 64'(i), 5'd0);
        check("t4_full_ready", 64'(req_ready), 64'd0);
        wait_drain("t4");
        for (int i = 0; i < 4; i++) check("t4_mem", mem_arr[i], 64'h1000 + 64'(i));

        // Misaligned accesses.
        send(1'b0, 64'h0C, 64'd0, 5'd9);
        send(1'b1, 64'h0C, 64'h77, 5'd0);
        @(negedge clk);
        check("t5_sb_empty", 64'(sb_empty), 64'd1);
        repeat (3) @(negedge clk);

        // Reset in the middle of a drain.
        send(1'b1, 64'h20, 64'hA1, 5'd0);
        send(1'b1, 64'h28, 64'hA2, 5'd0);
        send(1'b1, 64'h30, 64'hA3, 5'd0);
        b = 0;
        do begin
            @(negedge clk);
            #1;
            b++;
        end while (!mem_MemWrite && b < 50);
        check("t6_drain_started", 64'(mem_MemWrite), 64'd1);
        rst = 1'b1;
        pend_q.delete();
        @(negedge clk);
        check("t6_strobes", 64'({mem_MemRead, mem_MemWrite}), 64'd0);
        check("t6_sb_empty", 64'(sb_empty), 64'd1);
        check("t6_ready_in_rst", 64'(req_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("t6_ready_after", 64'(req_ready), 64'd1);

        // Random mix over a small set of words.
        for (int n = 0; n < 300; n++) begin
            bit          st;
            logic [63:0] addr;
            st   = 1'($urandom_range(0, 1));
            addr = 64'($urandom_range(0, 7)) << 3;
            if ($urandom_range(0, 9) == 0) addr = addr | 64'($urandom_range(1, 7));
            send(st, addr, {32'($urandom), 32'($urandom)}, 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain("rand");
        for (int i = 0; i < 8; i++) check("final_mem", mem_arr[i], commit[i]);
        check("rsp_q_left", 64'(rsp_q.size()), 64'd0);
        check("rd_q_left", 64'(rd_q.size()), 64'd0);
        check("fault_q_left", 64'(fault_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
